// File: rtl/tone_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Package  : tone_pkg                                                     |
// | Purpose  : Shared state encodings, status bit indices and default       |
// |            divisors for the tone generator.                             |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        GAP  = 2'b10
    } state_e;

    localparam int BUSY    = 0;
    localparam int PENDING = 1;

    localparam int C_PRESC_DIV = 250;
    localparam int C_DUR_DIV   = 25000;
    localparam int C_GAP_TICKS = 2;

    // A divisor of 1 still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_gen_tick_div.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tick_div                                                     |
// | Purpose  : Free-running divider producing a one-clock tick every DIV    |
// |            clocks; clr restarts the count from zero.                    |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
import tone_pkg::*;

module tick_div #(
    parameter int DIV = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int            W    = cnt_width(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tone_gen                                                     |
// | Purpose  : Memory-mapped square-wave tone generator: programmable       |
// |            half-period and duration followed by a silent gap.           |
// |            Define TONE_QUEUE_EN for a one-entry note queue.             |
// | Revision : 1.0                                                          |
// +-------------------------------------------------------------------------+
import tone_pkg::*;

module tone_gen #(
    parameter int PRESC_DIV = C_PRESC_DIV,
    parameter int DUR_DIV   = C_DUR_DIV,
    parameter int GAP_TICKS = C_GAP_TICKS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic       sel,
    input  logic [7:0] wd,
    output logic       audio,
    output logic       busy,
    output logic [7:0] status
);

    localparam int               GAP_W    = cnt_width((GAP_TICKS > 0) ? GAP_TICKS : 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    state_e           state_q, state_d;
    logic [7:0]       note_q, note_d;
    logic [7:0]       half_q, half_d;
    logic [7:0]       rem_q, rem_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             audio_q, audio_d;

    logic per_tick, dur_tick;
    logic restart, enter_gap, gap_done;
    logic is_busy, queue_hold, pending;

`ifdef TONE_QUEUE_EN
    logic       pending_q, pending_d;
    logic [7:0] pnote_q, pnote_d;
    logic [7:0] pdur_q, pdur_d;

    assign pending    = pending_q;
    assign queue_hold = is_busy;
`else
    assign pending    = 1'b0;
    assign queue_hold = 1'b0;
`endif

    assign is_busy = (state_q != IDLE);

    tick_div #(.DIV(PRESC_DIV)) u_period_div (
        .clk   (clk),
        .reset (reset),
        .clr   (restart),
        .tick  (per_tick)
    );

    tick_div #(.DIV(DUR_DIV)) u_dur_div (
        .clk   (clk),
        .reset (reset),
        .clr   (restart | enter_gap),
        .tick  (dur_tick)
    );

    // Any CPU write suppresses the internal tick-driven updates of that cycle.
    always_comb begin
        state_d   = state_q;
        note_d    = note_q;
        half_d    = half_q;
        rem_d     = rem_q;
        gap_d     = gap_q;
        audio_d   = audio_q;
        restart   = 1'b0;
        enter_gap = 1'b0;
        gap_done  = 1'b0;
`ifdef TONE_QUEUE_EN
        pending_d = pending_q;
        pnote_d   = pnote_q;
        pdur_d    = pdur_q;
`endif
        if (we && sel && (wd == 8'd0)) begin
            if (is_busy) begin
                state_d = IDLE;
                audio_d = 1'b0;
`ifdef TONE_QUEUE_EN
                pending_d = 1'b0;
`endif
            end
        end else if (we && sel && !queue_hold) begin
            rem_d   = wd;
            state_d = PLAY;
            restart = 1'b1;
        end else if (we && !sel && !queue_hold) begin
            note_d = wd;
            if (state_q == PLAY) begin
                half_d  = '0;
                audio_d = 1'b0;
            end
`ifdef TONE_QUEUE_EN
        end else if (we && sel) begin
            pdur_d    = wd;
            pending_d = 1'b1;
        end else if (we) begin
            pnote_d = wd;
`endif
        end else begin
            case (state_q)
                PLAY: begin
                    if (per_tick && (note_q != 8'd0)) begin
                        if (half_q == note_q - 8'd1) begin
                            half_d  = '0;
                            audio_d = ~audio_q;
                        end else begin
                            half_d = half_q + 8'd1;
                        end
                    end
                    if (dur_tick) begin
                        rem_d = rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            audio_d = 1'b0;
                            if (GAP_TICKS == 0) begin
                                gap_done = 1'b1;
                            end else begin
                                state_d   = GAP;
                                gap_d     = '0;
                                enter_gap = 1'b1;
                            end
                        end
                    end
                end
                GAP: begin
                    if (dur_tick) begin
                        if (gap_q == GAP_LAST) begin
                            gap_done = 1'b1;
                        end else begin
                            gap_d = gap_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (gap_done) begin
            state_d = IDLE;
`ifdef TONE_QUEUE_EN
            if (pending_q) begin
                note_d    = pnote_q;
                rem_d     = pdur_q;
                pending_d = 1'b0;
                state_d   = PLAY;
                restart   = 1'b1;
            end
`endif
        end

        if (restart) begin
            half_d  = '0;
            audio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            note_q    <= '0;
            half_q    <= '0;
            rem_q     <= '0;
            gap_q     <= '0;
            audio_q   <= 1'b0;
`ifdef TONE_QUEUE_EN
            pending_q <= 1'b0;
            pnote_q   <= '0;
            pdur_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            half_q    <= half_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            audio_q   <= audio_d;
`ifdef TONE_QUEUE_EN
            pending_q <= pending_d;
            pnote_q   <= pnote_d;
            pdur_q    <= pdur_d;
`endif
        end
    end

    assign audio  = audio_q;
    assign busy   = is_busy;
    assign status = {6'b0, pending, is_busy};

endmodule
`default_nettype wire

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Memory-mapped square-wave tone generator for the piano processor.
- Sits directly downstream of the CPU output-port decoder: one decoder enable line drives `we`, and the register-file read data drives `wd`.
- Plays one note at a time: programmable half-period, programmable duration, then a fixed silent articulation gap.
- Returns a status byte the CPU reads back through an input-port mux.

Parameters:
- PRESC_DIV, 250: clocks per period tick (half-period unit).
- DUR_DIV, 25000: clocks per duration tick.
- GAP_TICKS, 2: duration ticks of forced silence after each note.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- we  in  1  write strobe from the port decoder, one clock wide
- sel  in  1  register select: 0 = note register, 1 = duration register plus start
- wd  in  8  write data
- audio  out  1  square-wave output
- busy  out  1  high in PLAY or GAP
- status  out  8  {6'b0, pending, busy}

Behaviour:
- Reset values: audio=0, busy=0, status=0, state=IDLE, all counters and registers 0, pending=0.
- States (2-bit): IDLE, PLAY, GAP.
- Prescalers:
  - period_tick pulses once every PRESC_DIV clocks; its counter clears on entry to PLAY.
  - dur_tick pulses once every DUR_DIV clocks; its counter clears on entry to PLAY and on entry to GAP.
- Note register `note` (8 bits) is the half-period in period_ticks. note=0 is a rest: audio held 0 while the duration still elapses.
- Writes with sel=0:
  - Load `note` (pending_note when the queue is active, see Optional Feature).
  - In PLAY, reload the half counter and force audio=0 on the next edge.
- Writes with sel=1, wd!=0:
  - Load `dur`.
  - From IDLE or GAP: enter PLAY on the same edge; busy=1 from the next cycle.
  - From PLAY: retrigger (remaining duration reloaded, counters cleared, audio=0).
- Writes with sel=1, wd=0:
  - In IDLE: ignored.
  - In PLAY or GAP: abort to IDLE; audio=0 on the next edge.
- PLAY:
  - The half counter counts period_ticks; when it reaches note-1 on a tick, audio toggles and the counter wraps to 0.
  - First toggle occurs note*PRESC_DIV clocks after PLAY entry.
  - Remaining duration decrements on each dur_tick. On reaching 0, go to GAP with audio=0.
- GAP:
  - Audio=0 for GAP_TICKS dur_ticks, then go to IDLE.
  - If GAP_TICKS=0, go PLAY -> IDLE directly.
- Simultaneous events: a CPU write in the same cycle as an internal transition wins; the write's effect is applied and the internal transition is discarded.
- Reset asserted mid-note: immediate return to reset values; no partial toggle.
- Width rules:
  - Prescaler counters are $clog2 of their divisor.
  - The remaining-duration counter is 8 bits, so a duration of N dur_ticks is exact for 1..255.

Optional Feature:
- Macro: TONE_QUEUE_EN.
- Defined:
  - A one-entry holding register (pending_note, pending_dur, pending flag).
  - While busy, sel=0 writes go to pending_note, and sel=1 writes with wd!=0 go to pending_dur and set pending=1 instead of retriggering.
  - At GAP completion with pending=1: copy the pending values into note/dur, clear pending, and enter PLAY (gapless sequencing).
  - A second sel=1 write while pending=1 overwrites the pending entry (last write wins).
  - An abort clears pending.
- Undefined: no holding registers; status[1] is tied to 0; behaviour is exactly as in Behaviour above.

Decomposition:
- Shared package tone_pkg holds:
  - State encodings: IDLE=2'b00, PLAY=2'b01, GAP=2'b10.
  - Status bit indices: BUSY=0, PENDING=1.
  - The default divisor constants.
- One sub-module, tick_div (parameter DIV; ports clk, reset, clr, tick), instantiated twice: once for period_tick and once for dur_tick.

Test Plan (PRESC_DIV=2, DUR_DIV=4, GAP_TICKS=1):
- Reset: reset pulsed mid-simulation during PLAY -> audio=0, busy=0, status=8'h00 within the same cycle.
- Basic note: write note=3, then dur=2 -> busy rises next cycle; audio toggles every 6 clocks; PLAY lasts 8 clocks, GAP 4 clocks, then busy=0.
- Rest: note=0, dur=3 -> audio stays 0 while busy=1 for 12+4 clocks.
- Retrigger without TONE_QUEUE_EN: write dur=5 six clocks into a dur=2 note -> duration reloads and busy lasts a further 20+4 clocks.
- Abort: dur=0 written during PLAY -> IDLE and audio=0 on the next edge; dur=0 written in IDLE -> no state change.
- Queue with TONE_QUEUE_EN:
  - Writing note=1 and dur=1 during a playing note sets status=8'h03.
  - At GAP end, the second note starts with no idle cycle and status returns to 8'h01.
